galvo_point_scheduler: RTL and testbench
========================================

// Module: galvo_point_scheduler
// PURPOSE
//  Sequences one vector point per transaction onto the two-channel 12-bit galvo DAC
//  (X on channel A, Y on channel B) over SPI, pulses the DAC latch, then drives the
//  laser colour for a dwell time. Blanks the laser after long jumps while mirrors settle.
//  Sits between the game/point generator and the header pins (csn/sclk/mosi/latchn/rgb).
// PARAMETERS
//  SCLK_DIV     2    clk cycles per SCLK half-period (>=1)
//  LATCH_CYC    2    dac_latchn low-pulse width, clk cycles (>=1)
//  DWELL        500  clk cycles laser_rgb shows the point colour
//  SETTLE       200  blank cycles after a long jump (0 disables)
//  BLANK_THRESH 256  jump (|dx|+|dy|) strictly above this triggers SETTLE
// PORTS
//  clk        in   1   system clock (50 MHz domain)
//  reset      in   1   async reset, active-low
//  enable     in   1   accept new points when high (dip switch)
//  pt_valid   in   1   point available
//  pt_ready   out  1   scheduler can accept point
//  pt_x       in   12  X DAC code
//  pt_y       in   12  Y DAC code
//  pt_rgb     in   3   laser colour {r,g,b}, 1 = on
//  laser_rgb  out  3   laser colour, active-high (inverted at pins elsewhere)
//  dac_csn    out  1   DAC chip select, active-low
//  dac_sclk   out  1   SPI clock, idle low
//  dac_mosi   out  1   SPI data, MSB first
//  dac_latchn out  1   DAC LDAC, active-low
//  busy       out  1   high in any state except IDLE
// BEHAVIOUR
//  Reset (async, reset=0): state IDLE, dac_csn=1, dac_sclk=0, dac_mosi=0, dac_latchn=1,
//   laser_rgb=0, pt_ready=0, busy=0, prev_x=prev_y=0. All outputs registered.
//  pt_ready = 1 only in IDLE with enable=1 (registered; 1 first edge after reset release).
//  Accept on clk edge with pt_valid & pt_ready (cycle T); point captured, nothing else sampled.
//  States: IDLE -> SHIFT_X -> GAP -> SHIFT_Y -> LATCH -> [SETTLE] -> DWELL -> IDLE.
//  Word format: {ch, 1'b0 BUF, 1'b1 GA_n, 1'b1 SHDN_n, code[11:0]}; X=16'h3xxx, Y=16'hBxxx.
//  SHIFT: csn low whole word; 16 bits of 2*SCLK_DIV cycles each; mosi set at bit start,
//   sclk low first SCLK_DIV cycles, high second; sclk returns low with csn high.
//  Timing, SCLK_DIV=2: csn low T+1..T+64; GAP csn high SCLK_DIV cycles T+65..T+66;
//   csn low T+67..T+130; LATCH latchn low T+131..T+130+LATCH_CYC; next state at T+133.
//  Jump = |pt_x-prev_x| + |pt_y-prev_y|, 13-bit unsigned, computed at accept; prev_* <= pt at accept.
//  Jump > BLANK_THRESH and SETTLE>0: laser_rgb=0 for SETTLE cycles, then pt_rgb for DWELL.
//   Otherwise pt_rgb for DWELL directly; jump == BLANK_THRESH does not blank.
//  laser_rgb holds previous colour through accept, SHIFT, GAP, LATCH (mirrors still at old point).
//  IDLE with no accept: laser_rgb <= 0 at next edge (starvation blanking, safety).
//  After DWELL: IDLE at T+133+[SETTLE]+DWELL; pt_ready=1 that cycle if enable.
//  enable low mid-point: current point completes incl. DWELL; then IDLE, pt_ready=0, laser 0.
//  reset mid-operation: immediate reset values, point discarded, no partial latch pulse.
//  pt_valid dropped after accept: ignored; captured data used.
// TESTING
//  1 Hold reset=0, toggle inputs -> csn=1,sclk=0,mosi=0,latchn=1,rgb=0,pt_ready=0,busy=0.
//  2 Accept x=12'h123,y=12'hABC,rgb=3'b101 from reset (jump 0x123+0xABC>256) -> words 16'h3123,
//    16'hBABC MSB-first, latchn low T+131..T+132, rgb=0 SETTLE cycles, 3'b101 DWELL, then IDLE.
//  3 Next point x=12'h130,y=12'hAC0 (jump 17) offered back-to-back -> no SETTLE; rgb stays
//    3'b101 through shift, never 0 between points; new rgb at T+133.
//  4 Jump exactly 256 -> no blanking; 257 -> SETTLE blanking present.
//  5 pt_valid=0 after dwell -> laser_rgb=0 one cycle after IDLE entry; csn stays 1.
//  6 enable=0 during SHIFT_Y -> point completes, pt_ready stays 0; reset=0 at SHIFT_X bit 5 ->
//    csn=1,sclk=0 immediately, no latchn pulse after release.

Source files
------------

// File: rtl/galvo_point_scheduler.sv
// galvo_point_scheduler
// Takes one vector point per handshake and shifts X then Y as 16-bit words into
// the two-channel 12-bit galvo DAC over SPI. It then pulses LDAC and shows the
// point colour on the laser for a dwell time. If the jump from the previous
// point is long, the laser stays dark for a settle time before the dwell.
// Every output comes straight from a flop.
module galvo_point_scheduler #(
    parameter int SCLK_DIV     = 2,    // clk cycles per SCLK half-period
    parameter int LATCH_CYC    = 2,    // LDAC low-pulse width in clk cycles
    parameter int DWELL        = 500,  // clk cycles the point colour is shown
    parameter int SETTLE       = 200,  // blank cycles after a long jump, 0 disables
    parameter int BLANK_THRESH = 256   // jumps strictly above this get blanked
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        enable_i,
    input  logic        pt_valid_i,
    output logic        pt_ready_o,
    input  logic [11:0] pt_x_i,
    input  logic [11:0] pt_y_i,
    input  logic [2:0]  pt_rgb_i,
    output logic [2:0]  laser_rgb_o,
    output logic        dac_csn_o,
    output logic        dac_sclk_o,
    output logic        dac_mosi_o,
    output logic        dac_latchn_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT_X,
        S_GAP,
        S_SHIFT_Y,
        S_LATCH,
        S_SETTLE,
        S_DWELL
    } state_e;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] SCLK_HALF_LAST = CNT_W'(SCLK_DIV - 1);
    localparam logic [CNT_W-1:0] SCLK_BIT_LAST  = CNT_W'(2 * SCLK_DIV - 1);
    localparam logic [CNT_W-1:0] LATCH_LAST     = CNT_W'(LATCH_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST    = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam logic [CNT_W-1:0] DWELL_LAST     = CNT_W'(DWELL - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [11:0]      x_q, x_d, y_q, y_d;
    logic [2:0]       rgb_q, rgb_d;
    logic [11:0]      prev_x_q, prev_x_d, prev_y_q, prev_y_d;
    logic             blank_q, blank_d;
    logic             ready_q, ready_d;
    logic             csn_q, csn_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             latchn_q, latchn_d;
    logic [2:0]       laser_q, laser_d;
    logic             busy_q, busy_d;

    // DAC word: {channel, BUF=0, GA_n=1, SHDN_n=1, code}.
    logic [15:0] word_x, word_y, cur_word, accept_word_x;
    logic [11:0] dx, dy;
    logic [12:0] jump;

    assign word_x        = {4'b0011, x_q};
    assign word_y        = {4'b1011, y_q};
    assign accept_word_x = {4'b0011, pt_x_i};
    assign cur_word      = (state_q == S_SHIFT_Y) ? word_y : word_x;

    // Manhattan jump distance from the previously accepted point.
    always_comb begin
        dx   = (pt_x_i >= prev_x_q) ? (pt_x_i - prev_x_q) : (prev_x_q - pt_x_i);
        dy   = (pt_y_i >= prev_y_q) ? (pt_y_i - prev_y_q) : (prev_y_q - pt_y_i);
        jump = {1'b0, dx} + {1'b0, dy};
    end

    // Next-state and next-output logic; outputs are computed one cycle ahead.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        x_d      = x_q;
        y_d      = y_q;
        rgb_d    = rgb_q;
        prev_x_d = prev_x_q;
        prev_y_d = prev_y_q;
        blank_d  = blank_q;
        ready_d  = ready_q;
        csn_d    = csn_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        latchn_d = latchn_q;
        laser_d  = laser_q;

        case (state_q)
            S_IDLE: begin
                if (pt_valid_i && ready_q) begin
                    // Accept the point. The laser keeps its old colour
                    // because the mirrors have not moved yet.
                    x_d      = pt_x_i;
                    y_d      = pt_y_i;
                    rgb_d    = pt_rgb_i;
                    prev_x_d = pt_x_i;
                    prev_y_d = pt_y_i;
                    blank_d  = (SETTLE > 0) && (int'(jump) > BLANK_THRESH);
                    ready_d  = 1'b0;
                    state_d  = S_SHIFT_X;
                    cnt_d    = '0;
                    bit_d    = 4'd15;
                    csn_d    = 1'b0;
                    sclk_d   = 1'b0;
                    mosi_d   = accept_word_x[15];
                end else begin
                    // Starved: blank the laser so the beam never parks on one spot.
                    ready_d = enable_i;
                    laser_d = 3'b000;
                end
            end

            S_SHIFT_X, S_SHIFT_Y: begin
                if (cnt_q == SCLK_BIT_LAST) begin
                    cnt_d  = '0;
                    sclk_d = 1'b0;
                    if (bit_q == 4'd0) begin
                        csn_d  = 1'b1;
                        mosi_d = 1'b0;
                        if (state_q == S_SHIFT_X) begin
                            state_d = S_GAP;
                        end else begin
                            state_d  = S_LATCH;
                            latchn_d = 1'b0;
                        end
                    end else begin
                        bit_d  = bit_q - 4'd1;
                        mosi_d = cur_word[bit_q - 4'd1];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == SCLK_HALF_LAST) begin
                        sclk_d = 1'b1;
                    end
                end
            end

            S_GAP: begin
                if (cnt_q == SCLK_HALF_LAST) begin
                    state_d = S_SHIFT_Y;
                    cnt_d   = '0;
                    bit_d   = 4'd15;
                    csn_d   = 1'b0;
                    mosi_d  = word_y[15];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_LATCH: begin
                if (cnt_q == LATCH_LAST) begin
                    latchn_d = 1'b1;
                    cnt_d    = '0;
                    if (blank_q) begin
                        state_d = S_SETTLE;
                        laser_d = 3'b000;
                    end else begin
                        state_d = S_DWELL;
                        laser_d = rgb_q;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = S_DWELL;
                    cnt_d   = '0;
                    laser_d = rgb_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DWELL: begin
                if (cnt_q == DWELL_LAST) begin
                    // Hold the colour into IDLE so back-to-back points never go dark.
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    ready_d = enable_i;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State, datapath and output registers; reset drops any point in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            rgb_q    <= '0;
            prev_x_q <= '0;
            prev_y_q <= '0;
            blank_q  <= 1'b0;
            ready_q  <= 1'b0;
            csn_q    <= 1'b1;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            latchn_q <= 1'b1;
            laser_q  <= 3'b000;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            x_q      <= x_d;
            y_q      <= y_d;
            rgb_q    <= rgb_d;
            prev_x_q <= prev_x_d;
            prev_y_q <= prev_y_d;
            blank_q  <= blank_d;
            ready_q  <= ready_d;
            csn_q    <= csn_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            latchn_q <= latchn_d;
            laser_q  <= laser_d;
            busy_q   <= busy_d;
        end
    end

    assign pt_ready_o   = ready_q;
    assign dac_csn_o    = csn_q;
    assign dac_sclk_o   = sclk_q;
    assign dac_mosi_o   = mosi_q;
    assign dac_latchn_o = latchn_q;
    assign laser_rgb_o  = laser_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_galvo_point_scheduler.sv
// Directed testbench for galvo_point_scheduler with the default parameters.
// It checks every output, every cycle, against timing worked out by hand.
module tb_galvo_point_scheduler;

    localparam int SET = 200;
    localparam int DW  = 500;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        pt_valid = 1'b0;
    logic        pt_ready;
    logic [11:0] pt_x = '0;
    logic [11:0] pt_y = '0;
    logic [2:0]  pt_rgb = '0;
    logic [2:0]  laser_rgb;
    logic        dac_csn, dac_sclk, dac_mosi, dac_latchn, busy;

    int n_vec = 0;
    int n_bad = 0;

    galvo_point_scheduler dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .enable_i    (enable),
        .pt_valid_i  (pt_valid),
        .pt_ready_o  (pt_ready),
        .pt_x_i      (pt_x),
        .pt_y_i      (pt_y),
        .pt_rgb_i    (pt_rgb),
        .laser_rgb_o (laser_rgb),
        .dac_csn_o   (dac_csn),
        .dac_sclk_o  (dac_sclk),
        .dac_mosi_o  (dac_mosi),
        .dac_latchn_o(dac_latchn),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    // Observed vector: {csn, sclk, mosi, latchn, rgb[2:0], busy, ready}
    function automatic logic [8:0] obs_vec();
        return {dac_csn, dac_sclk, dac_mosi, dac_latchn, laser_rgb, busy, pt_ready};
    endfunction

    task automatic test_reset();
        logic [8:0] obs;
        for (int i = 0; i < 6; i++) begin
            enable   = i[0];
            pt_valid = ~i[0];
            pt_x     = 12'($urandom);
            pt_y     = 12'($urandom);
            pt_rgb   = 3'($urandom);
            @(posedge clk); #1;
            obs = obs_vec();
            n_vec++;
            if (obs !== 9'b1_0_0_1_000_0_0) begin
                $display("FAIL reset[%0d]: got %b required %b", i, obs, 9'b1_0_0_1_000_0_0);
                n_bad++;
            end
        end
        pt_valid = 1'b0;
        enable   = 1'b1;
        rst_n    = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (pt_ready !== 1'b1) begin
            $display("FAIL ready_after_release: got %b required 1", pt_ready);
            n_bad++;
        end
    endtask

    // Offer one point, then check the whole transaction cycle by cycle up to
    // and including the IDLE entry cycle. Returns #1 after the IDLE entry edge.
    task automatic run_point(input logic [11:0] x, input logic [11:0] y,
                             input logic [2:0] rgb, input logic [2:0] prev_rgb,
                             input bit blank, input int drop_en_at, input string tag);
        logic [15:0] wx, wy;
        logic [8:0]  exp_v, obs, mask;
        logic        csn_e, sclk_e, mosi_e, latchn_e;
        logic [2:0]  rgb_e;
        int          s, last, b;
        bit          ok;
        wx = {4'h3, x};
        wy = {4'hB, y};
        pt_x = x; pt_y = y; pt_rgb = rgb; pt_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            if (pt_ready === 1'b1) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        n_vec++;
        if (!ok) begin
            $display("FAIL %s accept: pt_ready stayed %b, required 1", tag, pt_ready);
            n_bad++;
            pt_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;   // now in cycle T+1
        // Captured data must be used, not whatever is on the bus afterwards.
        pt_valid = 1'b0; pt_x = ~x; pt_y = ~y; pt_rgb = ~rgb;
        s    = blank ? SET : 0;
        last = 132 + s + DW;
        for (int k = 1; k <= last + 1; k++) begin
            csn_e = 1'b1; sclk_e = 1'b0; mosi_e = 1'b0;
            mask  = 9'h1FF;
            if (k >= 1 && k <= 64) begin
                b = (k - 1) / 4;
                csn_e = 1'b0; sclk_e = ((k - 1) % 4) >= 2; mosi_e = wx[15 - b];
            end else if (k >= 67 && k <= 130) begin
                b = (k - 67) / 4;
                csn_e = 1'b0; sclk_e = ((k - 67) % 4) >= 2; mosi_e = wy[15 - b];
            end else begin
                mask[6] = 1'b0;
            end
            latchn_e = !(k == 131 || k == 132);
            if (k <= 132)          rgb_e = prev_rgb;
            else if (k <= 132 + s) rgb_e = 3'b000;
            else                   rgb_e = rgb;
            exp_v = {csn_e, sclk_e, mosi_e, latchn_e, rgb_e,
                     (k <= last) ? 1'b1 : 1'b0,
                     (k > last && drop_en_at == 0) ? 1'b1 : 1'b0};
            obs = obs_vec() & mask;
            n_vec++;
            if (obs !== (exp_v & mask)) begin
                $display("FAIL %s T+%0d: csn,sclk,mosi,latchn,rgb,busy,rdy got %b required %b",
                         tag, k, obs, exp_v & mask);
                n_bad++;
            end
            if (k == drop_en_at) enable = 1'b0;
            if (k <= last) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_first_point();
        run_point(12'h123, 12'hABC, 3'b101, 3'b000, 1'b1, 0, "first_point");
    endtask

    task automatic test_back_to_back();
        run_point(12'h130, 12'hAC0, 3'b011 ^ 3'b110, 3'b101, 1'b0, 0, "b2b_jump17");
    endtask

    task automatic test_threshold();
        run_point(12'h230, 12'hAC0, 3'b011, 3'b101, 1'b0, 0, "jump256");
        run_point(12'h330, 12'hAC1, 3'b110, 3'b011, 1'b1, 0, "jump257");
    endtask

    task automatic test_starvation();
        logic [8:0] obs;
        pt_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            obs = obs_vec() & 9'b110111111;
            n_vec++;
            if (obs !== 9'b1_0_0_1_000_0_1) begin
                $display("FAIL starve[%0d]: got %b required %b", i, obs, 9'b1_0_0_1_000_0_1);
                n_bad++;
            end
        end
    endtask

    task automatic test_enable_drop();
        logic [8:0] obs;
        run_point(12'h331, 12'hAC1, 3'b111, 3'b000, 1'b0, 80, "enable_drop");
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            obs = obs_vec() & 9'b110111111;
            n_vec++;
            if (obs !== 9'b1_0_0_1_000_0_0) begin
                $display("FAIL en_low_idle[%0d]: got %b required %b", i, obs, 9'b1_0_0_1_000_0_0);
                n_bad++;
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [8:0] obs;
        int latch_lows, csn_lows;
        bit ok;
        enable = 1'b1;
        pt_x = 12'h555; pt_y = 12'h222; pt_rgb = 3'b010; pt_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (pt_ready === 1'b1) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        n_vec++;
        if (!ok) begin
            $display("FAIL rstmid accept: pt_ready stayed %b, required 1", pt_ready);
            n_bad++;
        end
        @(posedge clk); #1;   // T+1
        pt_valid = 1'b0;
        for (int k = 1; k < 22; k++) begin
            @(posedge clk); #1;
        end
        // T+22: inside bit 5 of the X word, sclk low phase.
        n_vec++;
        if (dac_csn !== 1'b0) begin
            $display("FAIL rstmid pre: csn got %b required 0", dac_csn);
            n_bad++;
        end
        rst_n = 1'b0;
        #1;
        obs = obs_vec();
        n_vec++;
        if (obs !== 9'b1_0_0_1_000_0_0) begin
            $display("FAIL rstmid async: got %b required %b", obs, 9'b1_0_0_1_000_0_0);
            n_bad++;
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        latch_lows = 0;
        csn_lows   = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (dac_latchn !== 1'b1) latch_lows++;
            if (dac_csn !== 1'b1) csn_lows++;
        end
        n_vec++;
        if (latch_lows !== 0) begin
            $display("FAIL rstmid latch: latchn low cycles got %0d required 0", latch_lows);
            n_bad++;
        end
        n_vec++;
        if (csn_lows !== 0) begin
            $display("FAIL rstmid csn: csn low cycles got %0d required 0", csn_lows);
            n_bad++;
        end
        n_vec++;
        if (pt_ready !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL rstmid idle: ready,busy got %b%b required 10", pt_ready, busy);
            n_bad++;
        end
    endtask

    initial begin
        test_reset();
        test_first_point();
        test_back_to_back();
        test_threshold();
        test_starvation();
        test_enable_drop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
